// File: rtl/tt_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tt_pkg : shared types and sizing helpers for truth_table_engine      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } tt_state_e;

  function automatic int tt_rows(input int in_w);
    return 1 << in_w;
  endfunction

  // Keeps cfg_sel at least one bit wide when only a single function exists.
  function automatic int tt_sel_w(input int num_out);
    return (num_out > 1) ? $clog2(num_out) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/truth_table_engine_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | truth_table_engine_if : config, direct-evaluate and sweep signals    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface truth_table_engine_if #(
  parameter int IN_W    = 4,
  parameter int NUM_OUT = 10
);

  localparam int ROWS  = tt_pkg::tt_rows(IN_W);
  localparam int SEL_W = tt_pkg::tt_sel_w(NUM_OUT);

  logic               cfg_we;
  logic [SEL_W-1:0]   cfg_sel;
  logic [ROWS-1:0]    cfg_data;
  logic [IN_W-1:0]    in_vec;
  logic               in_valid;
  logic [NUM_OUT-1:0] eval;
  logic               eval_valid;
  logic               sweep_start;
  logic [IN_W-1:0]    row_idx;
  logic [NUM_OUT-1:0] row_val;
  logic               row_valid;
  logic               row_ready;
  logic               busy;
  logic               done;

  modport master (
    output cfg_we, cfg_sel, cfg_data, in_vec, in_valid, sweep_start, row_ready,
    input  eval, eval_valid, row_idx, row_val, row_valid, busy, done
  );

  modport slave (
    input  cfg_we, cfg_sel, cfg_data, in_vec, in_valid, sweep_start, row_ready,
    output eval, eval_valid, row_idx, row_val, row_valid, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/tt_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tt_bank : NUM_OUT truth tables, one write port, two row read ports   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tt_bank
  import tt_pkg::*;
#(
  parameter int IN_W    = 4,
  parameter int NUM_OUT = 10,
  parameter int ROWS    = 16,
  parameter int SEL_W   = 4
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  input  wire logic               i_we,
  input  wire logic [SEL_W-1:0]   i_sel,
  input  wire logic [ROWS-1:0]    i_data,
  input  wire logic [IN_W-1:0]    i_row_a,
  output logic      [NUM_OUT-1:0] o_val_a,
  input  wire logic [IN_W-1:0]    i_row_b,
  output logic      [NUM_OUT-1:0] o_val_b
);

  // Selects at or beyond NUM_OUT match no table, so they fall away naturally.
  for (genvar k = 0; k < NUM_OUT; k++) begin : g_tab
    logic [ROWS-1:0] r_tbl;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_tbl <= '0;
      end else if (i_we && (i_sel == SEL_W'(k))) begin
        r_tbl <= i_data;
      end
    end

    assign o_val_a[k] = r_tbl[i_row_a];
    assign o_val_b[k] = r_tbl[i_row_b];
  end

endmodule

`default_nettype wire

// File: rtl/truth_table_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | truth_table_engine : programmable multi-output truth tables with     |
// | direct evaluation and a flow-controlled full-table sweep. Rev 1.0    |
// +----------------------------------------------------------------------+
module truth_table_engine
  import tt_pkg::*;
#(
  parameter int IN_W    = 4,
  parameter int NUM_OUT = 10
) (
  input wire logic             clk,
  input wire logic             rst_n,
  truth_table_engine_if.slave  bus
);

  localparam int ROWS  = tt_rows(IN_W);
  localparam int SEL_W = tt_sel_w(NUM_OUT);

  tt_state_e          r_state;
  logic [IN_W-1:0]    r_row_idx;
  logic               r_busy;
  logic               r_done;
  logic [NUM_OUT-1:0] r_eval;
  logic               r_eval_valid;

  logic               w_we;
  logic               w_last;
  logic [NUM_OUT-1:0] w_eval_row;
  logic [NUM_OUT-1:0] w_sweep_row;

  // Tables are frozen during a sweep so every beat reports one consistent table.
  assign w_we   = bus.cfg_we & ~r_busy;
  assign w_last = (r_row_idx == {IN_W{1'b1}});

  tt_bank #(
    .IN_W    (IN_W),
    .NUM_OUT (NUM_OUT),
    .ROWS    (ROWS),
    .SEL_W   (SEL_W)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_sel   (bus.cfg_sel),
    .i_data  (bus.cfg_data),
    .i_row_a (bus.in_vec),
    .o_val_a (w_eval_row),
    .i_row_b (r_row_idx),
    .o_val_b (w_sweep_row)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_eval       <= '0;
      r_eval_valid <= 1'b0;
    end else begin
      r_eval_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_eval <= w_eval_row;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_row_idx <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.sweep_start) begin
            r_state   <= SWEEP;
            r_row_idx <= '0;
            r_busy    <= 1'b1;
          end
        end
        SWEEP: begin
          if (bus.row_ready) begin
            if (w_last) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_row_idx <= r_row_idx + 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.eval       = r_eval;
  assign bus.eval_valid = r_eval_valid;
  assign bus.row_idx    = r_row_idx;
  assign bus.row_valid  = r_busy;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.row_val    = r_busy ? w_sweep_row : '0;

endmodule

`default_nettype wire

// File: tb/tb_truth_table_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_truth_table_engine : directed + random bench with reference model |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_truth_table_engine;

  localparam int IN_W    = 4;
  localparam int NUM_OUT = 10;
  localparam int ROWS    = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  truth_table_engine_if #(.IN_W(IN_W), .NUM_OUT(NUM_OUT)) bus ();

  truth_table_engine #(.IN_W(IN_W), .NUM_OUT(NUM_OUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: tables as plain words, sweep as phase 0/1/2 = idle/sweep/done.
  logic [ROWS-1:0]    m_tbl [NUM_OUT];
  logic [NUM_OUT-1:0] m_eval;
  bit                 m_eval_valid;
  int                 m_phase;
  int                 m_row;
  int                 p_old;

  function automatic logic [NUM_OUT-1:0] m_lookup(input int row);
    logic [NUM_OUT-1:0] r;
    for (int k = 0; k < NUM_OUT; k++) r[k] = m_tbl[k][row];
    return r;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NUM_OUT; k++) m_tbl[k] = '0;
    m_eval       = '0;
    m_eval_valid = 1'b0;
    m_phase      = 0;
    m_row        = 0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial model_clear();
  always @(negedge rst_n) model_clear();

  always @(posedge clk) begin
    if (rst_n) begin
      p_old = m_phase;
      if (bus.in_valid) m_eval = m_lookup(int'(bus.in_vec));
      m_eval_valid = bus.in_valid;
      case (p_old)
        0: if (bus.sweep_start) begin m_phase = 1; m_row = 0; end
        1: if (bus.row_ready) begin
             if (m_row == ROWS - 1) m_phase = 2;
             else m_row = m_row + 1;
           end
        default: m_phase = 0;
      endcase
      if (bus.cfg_we && int'(bus.cfg_sel) < NUM_OUT && p_old != 1)
        m_tbl[bus.cfg_sel] = bus.cfg_data;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("eval_valid", 32'(bus.eval_valid), 32'(m_eval_valid));
      chk("eval",       32'(bus.eval),       32'(m_eval));
      chk("busy",       32'(bus.busy),       32'(m_phase == 1));
      chk("row_valid",  32'(bus.row_valid),  32'(m_phase == 1));
      chk("done",       32'(bus.done),       32'(m_phase == 2));
      if (m_phase == 1) begin
        chk("row_idx", 32'(bus.row_idx), 32'(m_row));
        chk("row_val", 32'(bus.row_val), 32'(m_lookup(m_row)));
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input int sel, input logic [15:0] d);
    bus.cfg_we   = 1'b1;
    bus.cfg_sel  = 4'(sel);
    bus.cfg_data = d;
    cyc();
    bus.cfg_we   = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_eval"},       32'(bus.eval),       32'h0);
    chk({tag, "_eval_valid"}, 32'(bus.eval_valid), 32'h0);
    chk({tag, "_busy"},       32'(bus.busy),       32'h0);
    chk({tag, "_done"},       32'(bus.done),       32'h0);
    chk({tag, "_row_valid"},  32'(bus.row_valid),  32'h0);
    chk({tag, "_row_idx"},    32'(bus.row_idx),    32'h0);
    chk({tag, "_row_val"},    32'(bus.row_val),    32'h0);
  endtask

  initial begin
    int beats, last_c, done_c, stall, vcnt;
    logic [NUM_OUT-1:0] held;
    bit found;

    bus.cfg_we = 0; bus.cfg_sel = '0; bus.cfg_data = '0;
    bus.in_vec = '0; bus.in_valid = 0; bus.sweep_start = 0; bus.row_ready = 0;

    #1;
    chk_all_zero("reset");
    cyc();
    rst_n = 1'b1;

    // Basic load and direct evaluate of row 6.
    wr(0, 16'hCCCC);
    wr(3, 16'hFFF0);
    bus.in_valid = 1; bus.in_vec = 4'b0110;
    cyc();
    bus.in_valid = 0;
    chk("direct_eval0", 32'(bus.eval[0]), 32'h1);
    chk("direct_eval3", 32'(bus.eval[3]), 32'h1);
    chk("direct_valid", 32'(bus.eval_valid), 32'h1);

    // Full sweep with row_ready held high.
    bus.sweep_start = 1; bus.row_ready = 1;
    cyc();
    bus.sweep_start = 0;
    beats = 0; last_c = -1; done_c = -1;
    for (int c = 0; c < 40 && done_c < 0; c++) begin
      if (bus.row_valid) begin
        chk("sweep_idx",  32'(bus.row_idx),    32'(beats));
        chk("sweep_val3", 32'(bus.row_val[3]), 32'(beats >= 4));
        beats++;
        last_c = c;
      end
      if (bus.done) done_c = c;
      cyc();
    end
    chk("sweep_beats", 32'(beats), 32'd16);
    chk("done_after_last", 32'(done_c - last_c), 32'd1);

    // Stalled sweep; writes attempted while busy must be dropped.
    bus.sweep_start = 1;
    cyc();
    bus.sweep_start = 0;
    stall = 0; vcnt = 0; done_c = -1; held = '0;
    for (int c = 0; c < 60 && done_c < 0; c++) begin
      bus.cfg_we = 0;
      if (bus.done) done_c = c;
      if (bus.row_valid) vcnt++;
      if (bus.row_valid && bus.row_idx == 4'd5) begin
        if (stall == 0) held = bus.row_val;
        else chk("stall_val", 32'(bus.row_val), 32'(held));
      end
      if (bus.row_valid && bus.row_idx == 4'd5 && stall < 3) begin
        bus.row_ready = 0;
        stall++;
      end else begin
        bus.row_ready = 1;
      end
      if (c == 2) begin bus.cfg_we = 1; bus.cfg_sel = 4'd3;  bus.cfg_data = 16'h0000; end
      if (c == 3) begin bus.cfg_we = 1; bus.cfg_sel = 4'd12; bus.cfg_data = 16'hFFFF; end
      cyc();
    end
    bus.cfg_we = 0;
    chk("stall_len", 32'(vcnt), 32'd19);
    bus.in_valid = 1; bus.in_vec = 4'b0100;
    cyc();
    bus.in_valid = 0;
    chk("t3_kept", 32'(bus.eval[3]), 32'h1);

    // Out-of-range selects while idle must not touch any table.
    wr(12, 16'hFFFF);
    wr(10, 16'hFFFF);
    bus.in_valid = 1; bus.in_vec = 4'b0110;
    cyc();
    bus.in_valid = 0;
    chk("oob_sel_eval", 32'(bus.eval), 32'h009);

    // Read-before-write on table 0.
    bus.cfg_we = 1; bus.cfg_sel = 4'd0; bus.cfg_data = 16'h0000;
    bus.in_valid = 1; bus.in_vec = 4'b0010;
    cyc();
    bus.cfg_we = 0;
    chk("rbw_old", 32'(bus.eval[0]), 32'h1);
    cyc();
    bus.in_valid = 0;
    chk("rbw_new", 32'(bus.eval[0]), 32'h0);

    // Asynchronous reset mid-sweep at row 7.
    wr(0, 16'hCCCC);
    bus.sweep_start = 1; bus.row_ready = 1;
    cyc();
    bus.sweep_start = 0;
    found = 0;
    for (int c = 0; c < 30 && !found; c++) begin
      if (bus.row_valid && bus.row_idx == 4'd7) found = 1;
      else cyc();
    end
    chk("reach_row7", 32'(found), 32'h1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    cyc();
    chk("midreset_nodone", 32'(bus.done), 32'h0);
    rst_n = 1'b1;
    bus.in_valid = 1; bus.in_vec = 4'b0110;
    cyc();
    chk("post_reset_eval", 32'(bus.eval), 32'h0);
    chk("post_reset_valid", 32'(bus.eval_valid), 32'h1);
    chk("post_reset_done", 32'(bus.done), 32'h0);

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      bus.cfg_we      = ($urandom % 6) == 0;
      bus.cfg_sel     = 4'($urandom % 16);
      bus.cfg_data    = 16'($urandom);
      bus.in_valid    = 1'($urandom % 2);
      bus.in_vec      = 4'($urandom);
      bus.sweep_start = ($urandom % 12) == 0;
      bus.row_ready   = ($urandom % 4) != 0;
      if (i == 1500) begin
        rst_n = 1'b0;
        #1;
        chk_all_zero("rand_reset");
        cyc();
        rst_n = 1'b1;
      end
      cyc();
    end

    bus.cfg_we = 0; bus.in_valid = 0; bus.sweep_start = 0; bus.row_ready = 1;
    repeat (20) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/truth_table_engine.md
TRUTH_TABLE_ENGINE -- requirements
Module: truth_table_engine

Interface
REQ-001 The block SHALL have parameter IN_W, default 4, meaning input vector width; ROWS = 2**IN_W.
REQ-002 The block SHALL have parameter NUM_OUT, default 10, meaning number of independent output functions.
REQ-003 The block SHALL have a single clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 cfg_we  in  1  truth-table write strobe.
REQ-006 cfg_sel  in  $clog2(NUM_OUT)  index of the function being written.
REQ-007 cfg_data  in  ROWS  truth table; bit r = output value for input row r.
REQ-008 in_vec  in  IN_W  direct-evaluate input, MSB = first variable (w in the 4-input case).
REQ-009 in_valid  in  1  qualifies in_vec.
REQ-010 eval  out  NUM_OUT  registered direct-evaluate result; bit k = function k.
REQ-011 eval_valid  out  1  eval is valid.
REQ-012 sweep_start  in  1  request a full truth-table sweep.
REQ-013 row_idx  out  IN_W  row index of the current sweep beat.
REQ-014 row_val  out  NUM_OUT  all function outputs for row_idx.
REQ-015 row_valid  out  1  sweep beat valid.
REQ-016 row_ready  in  1  consumer accepts the beat.
REQ-017 busy  out  1  sweep in progress.
REQ-018 done  out  1  one-cycle pulse at sweep completion.

Function
REQ-019 The block SHALL hold NUM_OUT table registers of ROWS bits; cfg_we=1 with cfg_sel<NUM_OUT writes cfg_data to table[cfg_sel] on the clock edge.
REQ-020 Writes with cfg_sel>=NUM_OUT, or while busy=1, SHALL be ignored with no other effect.
REQ-021 Direct mode: in_valid=1 in cycle n SHALL give eval[k]=table[k][in_vec] and eval_valid=1 in cycle n+1; in_valid=0 gives eval_valid=0 next cycle, eval holding its last value.
REQ-022 Direct mode SHALL operate in every FSM state, independent of sweeps.
REQ-023 A table write and an evaluation in the same cycle SHALL use the pre-write table (read-before-write).
REQ-024 FSM states SHALL be IDLE, SWEEP, DONE.
REQ-025 IDLE: sweep_start=1 -> SWEEP with row_idx=0; otherwise stay.
REQ-026 SWEEP: row_valid=1, busy=1, row_val[k]=table[k][row_idx].
REQ-027 SWEEP: on row_valid&row_ready, row_idx SHALL advance by 1; when row_idx=ROWS-1 the state SHALL go to DONE with no wrap.
REQ-028 SWEEP: with row_ready=0, row_idx and row_val SHALL remain stable.
REQ-029 DONE: done=1, row_valid=0, busy=0 for exactly one cycle, then IDLE.
REQ-030 sweep_start while in SWEEP or DONE SHALL be ignored.
REQ-031 With row_ready held 1, a sweep SHALL emit ROWS beats in ROWS consecutive cycles, and done SHALL assert the cycle after the last beat.

Reset
REQ-032 rst_n=0 SHALL asynchronously force state IDLE, all tables 0, row_idx 0, and eval, eval_valid, row_val, row_valid, busy, done to 0.
REQ-033 Reset mid-sweep SHALL abandon the sweep with no done pulse; the next sweep starts at row 0.

Structure
REQ-034 Package tt_pkg SHALL contain the FSM state typedef (IDLE/SWEEP/DONE) and a ROWS helper function of IN_W.
REQ-035 Table storage and row lookup SHALL be a sub-module tt_bank: NUM_OUT tables, one write port, two read ports (direct row, sweep row).

Verification
REQ-036 Load table0=16'hCCCC, table3=16'hFFF0; in_valid=1 with in_vec=4'b0110 -> next cycle eval[0]=1, eval[3]=1, eval_valid=1.
REQ-037 Load as REQ-036; pulse sweep_start, row_ready=1 -> 16 beats with row_idx 0..15, row_val[3]=0 for rows 0-3 and 1 for rows 4-15; done pulses one cycle later.
REQ-038 Drop row_ready for 3 cycles at row_idx=5 -> row_idx stays 5 and row_val is stable; the sweep then resumes at 6, and the total sweep length is 19 cycles.
REQ-039 Write cfg_sel=3, cfg_data=16'h0000 while busy -> ignored, table3 still 16'hFFF0; write with cfg_sel=12 -> ignored.
REQ-040 Assert rst_n=0 at row_idx=7 -> all outputs 0 immediately and no done pulse; direct eval of any in_vec returns 0.
REQ-041 Same-cycle write table0=16'h0000 and in_valid=1 with in_vec=4'b0010 -> eval[0]=1 (old table); the next evaluation gives 0.
